// File: rtl/mips_muldiv_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_muldiv_if : pipeline <-> multiply/divide unit request and result bus
// Rev 1.0
// ---------------------------------------------------------------------------
interface mips_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             cancel;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a_in, b_in, cancel, hi_we, lo_we, wdata,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, a_in, b_in, cancel, hi_we, lo_we, wdata,
      output busy, done, div_by_zero, hi, lo
   );
endinterface
`default_nettype wire

// File: rtl/mips_muldiv_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_muldiv_unit : radix-2 iterative MULT/MULTU/DIV/DIVU engine owning HI/LO
// Rev 1.0
// ---------------------------------------------------------------------------
module mips_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst,
   mips_muldiv_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             is_div_q, is_div_d;
   logic             neg_q, neg_d;
   logic             rem_neg_q, rem_neg_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] a_raw_q, a_raw_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
   logic             dbz_out_q, dbz_out_d;

   logic             sgn;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH:0]   sum, shifted, diff;
   logic [2*WIDTH-1:0] prod;

   always_comb begin
      state_d   = state_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      dbz_d     = dbz_q;
      a_raw_d   = a_raw_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      work_d    = work_q;
      count_d   = count_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dbz_out_d = 1'b0;

      sgn     = ~bus.op[0];
      a_abs   = (sgn && bus.a_in[WIDTH-1]) ? ('0 - bus.a_in) : bus.a_in;
      b_abs   = (sgn && bus.b_in[WIDTH-1]) ? ('0 - bus.b_in) : bus.b_in;
      // Multiply: add-and-shift; the product drains into work from the top.
      sum     = {1'b0, acc_q} + (work_q[0] ? {1'b0, mcand_q} : '0);
      // Divide: restoring step, quotient bits shift into work from the bottom.
      shifted = {acc_q, work_q[WIDTH-1]};
      diff    = shifted - {1'b0, mcand_q};
      prod    = neg_q ? ('0 - {acc_q, work_q}) : {acc_q, work_q};

      case (state_q)
         S_IDLE: begin
            if (bus.hi_we) hi_d = bus.wdata;
            if (bus.lo_we) lo_d = bus.wdata;
            if (bus.start && !bus.cancel) begin
               is_div_d  = bus.op[1];
               neg_d     = sgn && (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
               rem_neg_d = sgn && bus.a_in[WIDTH-1];
               dbz_d     = bus.op[1] && (bus.b_in == '0);
               a_raw_d   = bus.a_in;
               mcand_d   = bus.op[1] ? b_abs : a_abs;
               work_d    = bus.op[1] ? a_abs : b_abs;
               acc_d     = '0;
               count_d   = '0;
               state_d   = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.cancel) begin
               state_d = S_IDLE;
            end else begin
               if (is_div_q) begin
                  if (!diff[WIDTH]) begin
                     acc_d  = diff[WIDTH-1:0];
                     work_d = {work_q[WIDTH-2:0], 1'b1};
                  end else begin
                     acc_d  = shifted[WIDTH-1:0];
                     work_d = {work_q[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc_d  = sum[WIDTH:1];
                  work_d = {sum[0], work_q[WIDTH-1:1]};
               end
               count_d = count_q + 1'b1;
               if (count_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (!bus.cancel) begin
               done_d    = 1'b1;
               dbz_out_d = dbz_q;
               if (!is_div_q) begin
                  hi_d = prod[2*WIDTH-1:WIDTH];
                  lo_d = prod[WIDTH-1:0];
               end else if (dbz_q) begin
                  hi_d = a_raw_q;
                  lo_d = '1;
               end else begin
                  hi_d = rem_neg_q ? ('0 - acc_q) : acc_q;
                  lo_d = neg_q ? ('0 - work_q) : work_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         dbz_q     <= 1'b0;
         a_raw_q   <= '0;
         mcand_q   <= '0;
         acc_q     <= '0;
         work_q    <= '0;
         count_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dbz_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         dbz_q     <= dbz_d;
         a_raw_q   <= a_raw_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         work_q    <= work_d;
         count_q   <= count_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         dbz_out_q <= dbz_out_d;
      end
   end

   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_out_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mips_muldiv_unit : directed vector table plus multi-cycle corner sequences
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mips_muldiv_unit;
   localparam int W = 32;
   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mips_muldiv_if #(.WIDTH(W)) bus ();
   mips_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } vec_t;

   vec_t vecs[13];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Issue one op and wait for done; lat counts edges from E0 (E0 itself = 1).
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a_in  = a;
      bus.b_in  = b;
      tick();
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.a_in  = $urandom;
      bus.b_in  = $urandom;
      chk("busy_after_start", {31'b0, bus.busy}, 1);
      lat = 1;
      while (!bus.done && lat < 100) begin
         tick();
         lat++;
      end
      chk("done_seen", {31'b0, bus.done}, 1);
   endtask

   initial begin
      int lat, ndone, first;

      vecs[0]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      vecs[1]  = '{MULT,  -32'sd7,       32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0};
      vecs[2]  = '{DIV,   -32'sd7,       32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[3]  = '{DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
      vecs[4]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
      vecs[5]  = '{DIVU,  32'd10,        32'd3,         32'd1,         32'd3,         1'b0};
      vecs[6]  = '{MULTU, 32'd3,         32'd4,         32'd0,         32'd12,        1'b0};
      vecs[7]  = '{DIV,   32'd7,         -32'sd2,       32'd1,         32'hFFFF_FFFD, 1'b0};
      vecs[8]  = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
      vecs[9]  = '{DIV,   -32'sd8,       32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
      vecs[10] = '{DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0};
      vecs[11] = '{MULTU, 32'h1234_5678, 32'd0,         32'd0,         32'd0,         1'b0};
      vecs[12] = '{MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0};

      bus.start = 1'b0; bus.op = 2'b00; bus.a_in = '0; bus.b_in = '0;
      bus.cancel = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_busy", {31'b0, bus.busy}, 0);
      chk("rst_done", {31'b0, bus.done}, 0);
      chk("rst_dbz",  {31'b0, bus.div_by_zero}, 0);
      chk("rst_hi",   bus.hi, 0);
      chk("rst_lo",   bus.lo, 0);

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         chk($sformatf("v%0d_latency", i), lat, 34);
         chk($sformatf("v%0d_hi", i), bus.hi, vecs[i].hi);
         chk($sformatf("v%0d_lo", i), bus.lo, vecs[i].lo);
         chk($sformatf("v%0d_dbz", i), {31'b0, bus.div_by_zero}, {31'b0, vecs[i].dbz});
         chk($sformatf("v%0d_busy_at_done", i), {31'b0, bus.busy}, 0);
         tick();
         chk($sformatf("v%0d_done_pulse", i), {31'b0, bus.done}, 0);
      end

      // Reset mid-divide clears everything, then a fresh multiply works.
      bus.start = 1'b1; bus.op = DIV; bus.a_in = 32'd1000; bus.b_in = 32'd7;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c < 20; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", {31'b0, bus.busy}, 0);
      chk("midrst_done", {31'b0, bus.done}, 0);
      chk("midrst_hi", bus.hi, 0);
      chk("midrst_lo", bus.lo, 0);
      run_op(MULTU, 32'd3, 32'd4, lat);
      chk("postrst_lo", bus.lo, 12);
      chk("postrst_hi", bus.hi, 0);
      tick();

      // MTHI/MTLO in IDLE, then a cancelled divide leaves them untouched.
      bus.hi_we = 1'b1; bus.wdata = 32'd5;
      tick();
      bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'd9;
      tick();
      bus.lo_we = 1'b0;
      chk("mthi", bus.hi, 5);
      chk("mtlo", bus.lo, 9);
      bus.start = 1'b1; bus.op = DIVU; bus.a_in = 32'd10; bus.b_in = 32'd3;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c < 10; c++) tick();
      bus.cancel = 1'b1;
      tick();
      bus.cancel = 1'b0;
      chk("cancel_busy", {31'b0, bus.busy}, 0);
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.done) ndone++;
         tick();
      end
      chk("cancel_no_done", ndone, 0);
      chk("cancel_hi", bus.hi, 5);
      chk("cancel_lo", bus.lo, 9);

      // cancel in IDLE blocks a simultaneous start.
      bus.start = 1'b1; bus.cancel = 1'b1; bus.op = MULTU; bus.a_in = 32'd2; bus.b_in = 32'd2;
      tick();
      bus.start = 1'b0; bus.cancel = 1'b0;
      chk("idle_cancel_blocks", {31'b0, bus.busy}, 0);

      // Second start and MTHI while busy are both dropped.
      bus.start = 1'b1; bus.op = MULT; bus.a_in = -32'sd7; bus.b_in = 32'd6;
      tick();
      bus.start = 1'b0;
      lat = 1; ndone = 0; first = 0;
      while (lat < 60) begin
         if (lat == 5) begin
            bus.start = 1'b1; bus.op = DIVU; bus.a_in = 32'd1; bus.b_in = 32'd1;
            bus.hi_we = 1'b1; bus.wdata = 32'd1234;
         end else begin
            bus.start = 1'b0; bus.hi_we = 1'b0;
         end
         if (bus.done) begin
            ndone++;
            if (first == 0) begin
               first = lat;
               chk("busy_start_hi", bus.hi, 32'hFFFF_FFFF);
               chk("busy_start_lo", bus.lo, 32'hFFFF_FFD6);
            end
         end
         tick();
         lat++;
      end
      chk("busy_start_ndone", ndone, 1);
      chk("busy_start_latency", first, 34);

      // MTHI together with start: write lands now, result overwrites it later.
      bus.hi_we = 1'b1; bus.wdata = 32'd77;
      bus.start = 1'b1; bus.op = MULTU; bus.a_in = 32'd2; bus.b_in = 32'd3;
      tick();
      bus.start = 1'b0; bus.hi_we = 1'b0;
      chk("mthi_with_start_hi", bus.hi, 77);
      chk("mthi_with_start_busy", {31'b0, bus.busy}, 1);
      lat = 1;
      while (!bus.done && lat < 100) begin
         tick();
         lat++;
      end
      chk("mthi_with_start_lat", lat, 34);
      chk("mthi_with_start_res_hi", bus.hi, 0);
      chk("mthi_with_start_res_lo", bus.lo, 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
